// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle valid / frame-error pulses.
// Latency: pulse one clock after the stop-bit sample point; no backpressure, every frame is reported once.
module uart_rx #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err
);
  localparam int BAUD_DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          rx_meta_q;
  logic          rx_s_q;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q;
  logic          rx_busy_q;
  logic          frame_err_q;

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_busy   = rx_busy_q;
  assign frame_err = frame_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      rx_busy_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rx_s_q) begin
            state_q   <= START;
            rx_busy_q <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            bit_q <= '0;
            // A line that is high again at mid start bit was only a glitch.
            if (rx_s_q) begin
              state_q   <= IDLE;
              rx_busy_q <= 1'b0;
            end else begin
              state_q <= DATA;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == FULL_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rx_s_q, shift_q[7:1]};
            if (bit_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == FULL_LAST) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              state_q    <= IDLE;
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
              rx_busy_q  <= 1'b0;
            end else begin
              state_q     <= BREAK;
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        BREAK: begin
          // Wait out a held-low line so it cannot be taken as fresh start bits.
          cnt_q <= '0;
          if (rx_s_q) begin
            state_q   <= IDLE;
            rx_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          cnt_q     <= '0;
          rx_busy_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit: directed scenarios plus random traffic,
// all outputs compared every cycle against a sample-time model of the line.
module tb_uart_rx;
  localparam int DIV  = 16;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;

  uart_rx #(.CLK_FREQ_HZ(1_843_200), .BAUD_RATE(115_200)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_busy(rx_busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: timestamps the first low synchronized sample (T0) and reads the line at
  // T0+HALF+k*DIV; data bit i is taken at k=i+1, stop bit at k=9.
  int         cyc = 0;
  int         t0, k, bi;
  bit         m_act, m_brk, m_s1, m_s;
  logic [7:0] m_bits;
  logic [7:0] e_data;
  bit         e_vld, e_ferr, e_busy;

  always @(posedge clk) begin
    if (rst) begin
      m_act = 0; m_brk = 0; m_s1 = 1; m_s = 1;
      m_bits = 8'h00; e_data = 8'h00; e_vld = 0; e_ferr = 0; e_busy = 0;
    end else begin
      e_vld = 0; e_ferr = 0;
      if (m_brk) begin
        if (m_s) m_brk = 0;
      end else if (!m_act) begin
        if (!m_s) begin m_act = 1; t0 = cyc; end
      end else begin
        k = cyc - t0 - HALF;
        if (k == 0 && m_s) m_act = 0;
        else if (k > 0 && k % DIV == 0) begin
          bi = k / DIV - 1;
          if (bi < 8) m_bits[bi] = m_s;
          else begin
            m_act = 0;
            if (m_s) begin e_vld = 1; e_data = m_bits; end
            else begin e_ferr = 1; m_brk = 1; end
          end
        end
      end
      e_busy = m_act || m_brk;
      m_s  = m_s1;
      m_s1 = rx;
    end
    cyc++;
  end

  logic [7:0] vq[$];
  int         n_ferr = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rx_valid", {31'd0, rx_valid}, {31'd0, e_vld});
      chk("frame_err", {31'd0, frame_err}, {31'd0, e_ferr});
      chk("rx_busy", {31'd0, rx_busy}, {31'd0, e_busy});
      chk("rx_data", {24'd0, rx_data}, {24'd0, e_data});
      if (rx_valid === 1'b1) vq.push_back(rx_data);
      if (frame_err === 1'b1) n_ferr++;
    end
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop_v);
    hold(1'b0, DIV);
    for (int i = 0; i < 8; i++) hold(b[i], DIV);
    hold(stop_v, DIV);
  endtask

  task automatic clear();
    vq.delete();
    n_ferr = 0;
  endtask

  int n_good;
  logic [7:0] last_good, rb;

  initial begin
    rst = 1'b1; rx = 1'b1;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("reset_data", {24'd0, rx_data}, 32'h00);
    chk("reset_busy", {31'd0, rx_busy}, 32'd0);
    rst = 1'b0;
    idle(5);

    // Framing error with a long break afterwards.
    clear();
    send(8'h33, 1'b0);
    hold(1'b0, 40);
    chk("break_busy", {31'd0, rx_busy}, 32'd1);
    idle(6);
    chk("break_busy_release", {31'd0, rx_busy}, 32'd0);
    chk("ferr_count", n_ferr, 32'd1);
    chk("ferr_no_valid", vq.size(), 32'd0);
    chk("ferr_data_kept", {24'd0, rx_data}, 32'h00);
    idle(10);

    // Single byte.
    clear();
    send(8'h41, 1'b1);
    idle(20);
    chk("single_count", vq.size(), 32'd1);
    if (vq.size() > 0) chk("single_data", {24'd0, vq[0]}, 32'h41);
    chk("model_data_41", {24'd0, e_data}, 32'h41);
    chk("single_busy", {31'd0, rx_busy}, 32'd0);

    // Back-to-back frames.
    clear();
    send(8'h5A, 1'b1);
    send(8'hA5, 1'b1);
    idle(20);
    chk("b2b_count", vq.size(), 32'd2);
    if (vq.size() > 1) begin
      chk("b2b_first", {24'd0, vq[0]}, 32'h5A);
      chk("b2b_second", {24'd0, vq[1]}, 32'hA5);
    end

    // False start: 5-cycle glitch.
    clear();
    hold(1'b0, 4);
    chk("glitch_busy", {31'd0, rx_busy}, 32'd1);
    hold(1'b0, 1);
    idle(8);
    chk("glitch_idle", {31'd0, rx_busy}, 32'd0);
    idle(10);
    chk("glitch_no_valid", vq.size(), 32'd0);
    chk("glitch_no_ferr", n_ferr, 32'd0);
    chk("glitch_data_kept", {24'd0, rx_data}, 32'hA5);

    // Reset in the middle of data bit 3 of 0xC3.
    clear();
    rb = 8'hC3;
    hold(1'b0, DIV);
    for (int i = 0; i < 3; i++) hold(rb[i], DIV);
    hold(rb[3], DIV / 2);
    rst = 1'b1; rx = 1'b1;
    @(negedge clk);
    chk("midrst_data", {24'd0, rx_data}, 32'h00);
    chk("midrst_busy", {31'd0, rx_busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(20);
    chk("midrst_no_pulse", vq.size() + n_ferr, 32'd0);
    send(8'h7E, 1'b1);
    idle(20);
    chk("midrst_count", vq.size(), 32'd1);
    if (vq.size() > 0) chk("midrst_next", {24'd0, vq[0]}, 32'h7E);

    // Loopback bytes from the bench transmitter.
    clear();
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    send(8'h55, 1'b1);
    idle(20);
    chk("loop_count", vq.size(), 32'd3);
    if (vq.size() > 2) begin
      chk("loop_00", {24'd0, vq[0]}, 32'h00);
      chk("loop_ff", {24'd0, vq[1]}, 32'hFF);
      chk("loop_55", {24'd0, vq[2]}, 32'h55);
    end

    // Random traffic: good frames with random gaps, glitches and framing errors.
    clear();
    n_good = 0;
    last_good = 8'h55;
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 9))
        0: begin
          hold(1'b0, $urandom_range(1, HALF - 1));
          idle($urandom_range(HALF + 4, 20));
        end
        1: begin
          rb = 8'($urandom);
          send(rb, 1'b0);
          hold(1'b0, $urandom_range(0, 30));
          idle($urandom_range(4, 20));
        end
        default: begin
          rb = 8'($urandom);
          send(rb, 1'b1);
          n_good++;
          last_good = rb;
          idle($urandom_range(0, 20));
        end
      endcase
    end
    idle(30);
    chk("rand_count", vq.size(), n_good);
    chk("rand_last", {24'd0, rx_data}, {24'd0, last_good});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
